// File: rtl/shake_pkg.sv
// Shared SHAKE absorb definitions: controller FSM states and sponge constants.
package shake_pkg;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FLUSH
  } absorb_state_t;

  localparam int SHAKE128_RATE_WORDS = 21;
  localparam int SHAKE256_RATE_WORDS = 17;
  localparam logic [7:0] SHAKE_DOMAIN = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

endpackage

// File: rtl/sipo_buffer.sv
// Serial-in parallel-out word buffer; the first word shifted in ends up in the
// LSBs once DEPTH words have been loaded. No reset: contents are don't-care.
module sipo_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 21
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [DEPTH*WIDTH-1:0] data_o
);

  logic [DEPTH*WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= {din_i, data_q[DEPTH*WIDTH-1:WIDTH]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/sipo_absorb_ctrl.sv
// SHAKE absorb controller: packs message words into rate blocks, applies the
// domain byte and pad10*1. Optional counters via SIPO_ABSORB_CTRL_PERF_EN.
module sipo_absorb_ctrl
  import shake_pkg::*;
#(
  parameter int         WIDTH      = 64,
  parameter int         RATE_WORDS = SHAKE128_RATE_WORDS,
  parameter logic [7:0] DOMAIN     = SHAKE_DOMAIN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [$clog2(WIDTH/8):0]    in_bytes,
  output logic                        in_ready,
  output logic [RATE_WORDS*WIDTH-1:0] block_o,
  output logic                        block_valid,
  output logic                        block_last,
  input  logic                        block_ready
`ifdef SIPO_ABSORB_CTRL_PERF_EN
  ,
  output logic [31:0]                 perf_blocks,
  output logic [31:0]                 perf_stall
`endif
);

  localparam int NB = WIDTH / 8;
  localparam int CW = $clog2(RATE_WORDS + 1);

  absorb_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dom_q, dom_d;
  logic             ended_q, ended_d;
  logic             rdy_q, bv_q, bl_q;
  logic             buf_en;
  logic [WIDTH-1:0] buf_word;
  logic             last_slot;

  assign last_slot = (cnt_q == CW'(RATE_WORDS - 1));

  // Next-state logic also builds the word shifted into the buffer this cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dom_d    = dom_q;
    ended_d  = ended_q;
    buf_en   = 1'b0;
    buf_word = '0;
    unique case (state_q)
      FILL: begin
        if (in_valid && rdy_q) begin
          buf_en   = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          buf_word = in_data;
          if (in_last) begin
            ended_d = 1'b1;
            for (int b = 0; b < NB; b++) begin
              if (b == int'(in_bytes)) begin
                buf_word[8*b +: 8] = DOMAIN;
              end else if (b > int'(in_bytes)) begin
                buf_word[8*b +: 8] = 8'h00;
              end
            end
            if (int'(in_bytes) < NB) begin
              if (last_slot) begin
                buf_word[WIDTH-1 -: 8] = buf_word[WIDTH-1 -: 8] | PAD_END;
              end
            end else begin
              dom_d = 1'b1;
            end
          end
          if (last_slot) begin
            state_d = FLUSH;
          end else if (in_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        buf_en = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (dom_q) begin
          buf_word[7:0] = DOMAIN;
          dom_d         = 1'b0;
        end
        if (last_slot) begin
          buf_word[WIDTH-1 -: 8] = buf_word[WIDTH-1 -: 8] | PAD_END;
          state_d                = FLUSH;
        end
      end
      FLUSH: begin
        if (block_ready) begin
          cnt_d   = '0;
          ended_d = ended_q && dom_q;
          state_d = dom_q ? PAD : FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      dom_q   <= 1'b0;
      ended_q <= 1'b0;
      rdy_q   <= 1'b0;
      bv_q    <= 1'b0;
      bl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      ended_q <= ended_d;
      rdy_q   <= (state_d == FILL);
      bv_q    <= (state_d == FLUSH);
      bl_q    <= (state_d == FLUSH) && ended_d && !dom_d;
    end
  end

  sipo_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(RATE_WORDS)
  ) u_buf (
    .clk_i (clk),
    .en_i  (buf_en),
    .din_i (buf_word),
    .data_o(block_o)
  );

  assign in_ready    = rdy_q;
  assign block_valid = bv_q;
  assign block_last  = bl_q;

`ifdef SIPO_ABSORB_CTRL_PERF_EN
  logic [31:0] perf_blocks_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_blocks_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (bv_q && block_ready) perf_blocks_q <= perf_blocks_q + 32'd1;
      if (in_valid && !rdy_q)  perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_blocks = perf_blocks_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_sipo_absorb_ctrl.sv
// Self-checking bench for sipo_absorb_ctrl: a byte-level SHAKE padding model
// predicts every emitted block, plus literal checks on selected scenarios.
module tb_sipo_absorb_ctrl;

  localparam int W   = 64;
  localparam int NB  = W / 8;
  localparam int RW  = 21;
  localparam int RW2 = 17;
  localparam int RB  = RW * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  inData;
  logic          inValid, inLast;
  logic [3:0]    inBytes;
  logic          inReady;
  logic [RW*W-1:0] blockO;
  logic          blockValid, blockLast, blockReady;

  logic [W-1:0]  inData2;
  logic          inValid2, inLast2;
  logic [3:0]    inBytes2;
  logic          inReady2;
  logic [RW2*W-1:0] blockO2;
  logic          blockValid2, blockLast2, blockReady2;

`ifdef SIPO_ABSORB_CTRL_PERF_EN
  logic [31:0] perfBlocks, perfStall, perfBlocks2, perfStall2;
`endif

  sipo_absorb_ctrl #(.WIDTH(W), .RATE_WORDS(RW), .DOMAIN(8'h1F)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid), .in_last(inLast),
    .in_bytes(inBytes), .in_ready(inReady), .block_o(blockO), .block_valid(blockValid),
    .block_last(blockLast), .block_ready(blockReady)
`ifdef SIPO_ABSORB_CTRL_PERF_EN
    , .perf_blocks(perfBlocks), .perf_stall(perfStall)
`endif
  );

  sipo_absorb_ctrl #(.WIDTH(W), .RATE_WORDS(RW2), .DOMAIN(8'h1F)) dut17 (
    .clk(clk), .rst(rst), .in_data(inData2), .in_valid(inValid2), .in_last(inLast2),
    .in_bytes(inBytes2), .in_ready(inReady2), .block_o(blockO2), .block_valid(blockValid2),
    .block_last(blockLast2), .block_ready(blockReady2)
`ifdef SIPO_ABSORB_CTRL_PERF_EN
    , .perf_blocks(perfBlocks2), .perf_stall(perfStall2)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0]    msgWords[0:63];
  logic [RW*W-1:0] expData[$];
  logic            expLast[$];
  logic [RW*W-1:0] capData[$];
  logic            capLast[$];

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Standard SHAKE padding on a byte stream: message, domain byte, zero fill
  // to the rate, then 0x80 OR'd into the final byte of the final block.
  task automatic modelMessage(input int n, input int lastBytes);
    byte unsigned bq[$];
    logic [RW*W-1:0] blk;
    int nblk;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < ((i == n - 1) ? lastBytes : NB); b++) begin
        bq.push_back(msgWords[i][8*b +: 8]);
      end
    end
    bq.push_back(8'h1F);
    while (bq.size() % RB != 0) bq.push_back(8'h00);
    bq[bq.size() - 1] = bq[bq.size() - 1] | 8'h80;
    nblk = bq.size() / RB;
    for (int k = 0; k < nblk; k++) begin
      blk = '0;
      for (int j = 0; j < RB; j++) blk[8*j +: 8] = bq[k*RB + j];
      expData.push_back(blk);
      expLast.push_back(k == nblk - 1);
    end
  endtask

  task automatic driveWord(input logic [W-1:0] d, input logic l, input logic [3:0] nb);
    int guard = 0;
    inData  = d;
    inLast  = l;
    inBytes = nb;
    inValid = 1'b1;
    while (!inReady && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
    end
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int lastBytes);
    modelMessage(n, lastBytes);
    for (int i = 0; i < n; i++) begin
      driveWord(msgWords[i], (i == n - 1), (i == n - 1) ? 4'(lastBytes) : 4'(NB));
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (expData.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain_pending_blocks", 64'(expData.size()), 64'd0);
  endtask

  task automatic waitBlocks(input int n);
    int guard = 0;
    while (capData.size() < n && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("captured_block_count", 64'(capData.size()), 64'(n));
  endtask

  function automatic logic [W-1:0] capWord(input int idx, input int k);
    logic [RW*W-1:0] blk;
    if (idx >= capData.size()) return 'x;
    blk = capData[idx];
    return blk[k*W +: W];
  endfunction

  function automatic logic capLastAt(input int idx);
    if (idx >= capLast.size()) return 1'bx;
    return capLast[idx];
  endfunction

  // Compare process: samples one step after each falling edge, so values hold
  // for the coming rising edge where handshakes actually happen.
  initial begin
    logic [RW*W-1:0] prevBlock, e;
    logic prevHold, l;
    int stallModel, blocksModel;
    prevHold = 1'b0;
    prevBlock = '0;
    stallModel = 0;
    blocksModel = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prevHold = 1'b0;
        stallModel = 0;
        blocksModel = 0;
      end else begin
`ifdef SIPO_ABSORB_CTRL_PERF_EN
        checkOutput("perf_stall", 64'(perfStall), 64'(stallModel));
        checkOutput("perf_blocks", 64'(perfBlocks), 64'(blocksModel));
        if (inValid && !inReady) stallModel++;
        if (blockValid && blockReady) blocksModel++;
`endif
        if (blockValid) checkOutput("in_ready_while_block_valid", 64'(inReady), 64'd0);
        if (prevHold) begin
          checkOutput("block_valid_held", 64'(blockValid), 64'd1);
          for (int k = 0; k < RW; k++) begin
            if (blockO[k*W +: W] !== prevBlock[k*W +: W]) begin
              checkOutput($sformatf("block_stable_word%0d", k), blockO[k*W +: W], prevBlock[k*W +: W]);
            end
          end
        end
        if (blockValid && blockReady) begin
          if (expData.size() == 0) begin
            checkOutput("unexpected_block_count", 64'd1, 64'd0);
          end else begin
            e = expData.pop_front();
            l = expLast.pop_front();
            for (int k = 0; k < RW; k++) begin
              checkOutput($sformatf("block_word%0d", k), blockO[k*W +: W], e[k*W +: W]);
            end
            checkOutput("block_last", 64'(blockLast), 64'(l));
          end
          capData.push_back(blockO);
          capLast.push_back(blockLast);
        end
        prevHold  = blockValid && !blockReady;
        prevBlock = blockO;
      end
    end
  end

  initial begin
    int cycles;
    logic [31:0] stall0;
    logic [RW2*W-1:0] blk2;
    rst = 1'b0;
    inData = 64'hDEAD_BEEF_DEAD_BEEF;
    inValid = 1'b1;
    inLast = 1'b0;
    inBytes = 4'd8;
    blockReady = 1'b1;
    inData2 = '0;
    inValid2 = 1'b0;
    inLast2 = 1'b0;
    inBytes2 = 4'd0;
    blockReady2 = 1'b0;
    stall0 = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(inReady), 64'd0);
    checkOutput("reset_block_valid", 64'(blockValid), 64'd0);
    checkOutput("reset_block_last", 64'(blockLast), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 64'(inReady), 64'd1);
    checkOutput("release_block_valid", 64'(blockValid), 64'd0);
    inValid = 1'b0;
    @(negedge clk);

    $display("[TB] full-width last word in final slot");
    capData.delete(); capLast.delete();
    for (int i = 0; i < RW; i++) msgWords[i] = 64'(i);
    applyStimulus(RW, 8);
    waitBlocks(2);
    checkOutput("fw_b1_word0", capWord(0, 0), 64'd0);
    checkOutput("fw_b1_word7", capWord(0, 7), 64'd7);
    checkOutput("fw_b1_word20", capWord(0, 20), 64'd20);
    checkOutput("fw_b1_last", 64'(capLastAt(0)), 64'd0);
    checkOutput("fw_b2_word0", capWord(1, 0), 64'h1F);
    checkOutput("fw_b2_word10", capWord(1, 10), 64'd0);
    checkOutput("fw_b2_word20", capWord(1, 20), 64'h8000_0000_0000_0000);
    checkOutput("fw_b2_last", 64'(capLastAt(1)), 64'd1);
    drain();

    $display("[TB] partial last word in final slot");
    capData.delete(); capLast.delete();
    for (int i = 0; i < RW - 1; i++) msgWords[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
    msgWords[RW-1] = 64'h0000_0000_00AA_BBCC;
    applyStimulus(RW, 3);
    waitBlocks(1);
    repeat (3) @(negedge clk);
    checkOutput("p3_block_count", 64'(capData.size()), 64'd1);
    checkOutput("p3_word20", capWord(0, 20), 64'h8000_0000_1FAA_BBCC);
    checkOutput("p3_word19", capWord(0, 19), 64'h1414_1414_1414_1414);
    checkOutput("p3_last", 64'(capLastAt(0)), 64'd1);
    drain();

    $display("[TB] full last word in slot 19, domain and end byte share word 20");
    capData.delete(); capLast.delete();
    for (int i = 0; i < RW - 1; i++) msgWords[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
    applyStimulus(RW - 1, 8);
    waitBlocks(1);
    checkOutput("s19_word20", capWord(0, 20), 64'h8000_0000_0000_001F);
    checkOutput("s19_word19", capWord(0, 19), 64'hA5A5_0000_0000_0013);
    drain();

    $display("[TB] seven-byte last word in final slot");
    for (int i = 0; i < RW; i++) msgWords[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    capData.delete(); capLast.delete();
    applyStimulus(RW, 7);
    waitBlocks(1);
    checkOutput("b7_word20", capWord(0, 20), 64'h9FFF_FFFF_FFFF_FFFF);
    drain();

    $display("[TB] empty last word after a full block");
    for (int i = 0; i < RW + 1; i++) msgWords[i] = 64'h5555_0000_0000_0000 ^ 64'(i * 3);
    applyStimulus(RW + 1, 0);
    drain();

    $display("[TB] back-pressure in flush");
    capData.delete(); capLast.delete();
    blockReady = 1'b0;
    msgWords[0] = 64'h1111_2222_3333_4444;
    msgWords[1] = 64'h5555_6666_7777_8888;
    msgWords[2] = 64'hFFEE_DDCC_BBAA_9988;
    applyStimulus(3, 5);
    cycles = 0;
    while (!blockValid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("bp_block_valid_seen", 64'(blockValid), 64'd1);
    inData = 64'h0000_0000_0000_1234;
    inValid = 1'b1;
`ifdef SIPO_ABSORB_CTRL_PERF_EN
    stall0 = perfStall;
`endif
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("bp_block_valid", 64'(blockValid), 64'd1);
      checkOutput("bp_in_ready", 64'(inReady), 64'd0);
    end
`ifdef SIPO_ABSORB_CTRL_PERF_EN
    checkOutput("bp_perf_stall_delta", 64'(perfStall - stall0), 64'd10);
`endif
    checkOutput("bp_word2", blockO[2*W +: W], 64'h0000_1FCC_BBAA_9988);
    checkOutput("bp_word20", blockO[20*W +: W], 64'h8000_0000_0000_0000);
    blockReady = 1'b1;
    msgWords[0] = 64'h0000_0000_0000_1234;
    applyStimulus(1, 2);
    waitBlocks(2);
    checkOutput("bp_next_word0", capWord(1, 0), 64'h0000_0000_001F_1234);
    drain();

    $display("[TB] reset mid-fill");
    for (int i = 0; i < 5; i++) driveWord(64'hBAD0_0000_0000_0000 + 64'(i), 1'b0, 4'd8);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    capData.delete(); capLast.delete();
    msgWords[0] = 64'h0123_4567_89AB_CDEF;
    applyStimulus(1, 8);
    waitBlocks(1);
    checkOutput("mr_word0", capWord(0, 0), 64'h0123_4567_89AB_CDEF);
    checkOutput("mr_word1", capWord(0, 1), 64'h1F);
    checkOutput("mr_word5", capWord(0, 5), 64'd0);
    checkOutput("mr_word20", capWord(0, 20), 64'h8000_0000_0000_0000);
    checkOutput("mr_last", 64'(capLastAt(0)), 64'd1);
    drain();

    $display("[TB] empty message, 17-word rate");
    inData2 = 64'hFFFF_FFFF_FFFF_FFFF;
    inLast2 = 1'b1;
    inBytes2 = 4'd0;
    inValid2 = 1'b1;
    cycles = 0;
    while (!inReady2 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("e17_in_ready", 64'(inReady2), 64'd1);
    @(negedge clk);
    inValid2 = 1'b0;
    inLast2 = 1'b0;
    cycles = 1;
    while (!blockValid2 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("e17_latency", 64'(cycles), 64'd17);
    blk2 = blockO2;
    checkOutput("e17_word0", blk2[0 +: W], 64'h1F);
    checkOutput("e17_word8", blk2[8*W +: W], 64'd0);
    checkOutput("e17_word16", blk2[16*W +: W], 64'h8000_0000_0000_0000);
    checkOutput("e17_last", 64'(blockLast2), 64'd1);
    checkOutput("e17_in_ready_flush", 64'(inReady2), 64'd0);
    blockReady2 = 1'b1;
    @(negedge clk);
    checkOutput("e17_valid_drop", 64'(blockValid2), 64'd0);
    checkOutput("e17_in_ready_back", 64'(inReady2), 64'd1);
    blockReady2 = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_absorb_ctrl.md
Name: sipo_absorb_ctrl

Overview:
- Absorb-side controller for the SHAKE core.
- Accepts a message word stream over a valid/ready handshake and shifts it into a sipo_buffer instance.
- Applies SHAKE padding (domain byte plus pad10*1) at end of message.
- Presents each completed rate block to the permutation core over a block_valid/block_ready handshake, back-pressuring the input while a block is pending.

Parameters:
- WIDTH, 64, word width in bits; multiple of 8.
- RATE_WORDS, 21, words per rate block (21 for SHAKE128, 17 for SHAKE256).
- DOMAIN, 8'h1F, domain-separation/first padding byte.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  message word, little-endian bytes
- in_valid  input  1  in_data valid
- in_last  input  1  final word of message
- in_bytes  input  $clog2(WIDTH/8)+1  valid bytes in final word (0..WIDTH/8); ignored unless in_last
- in_ready  output  1  controller accepts word
- block_o  output  RATE_WORDS*WIDTH  assembled block; word 0 in LSBs
- block_valid  output  1  block_o complete
- block_last  output  1  block is the final (padded) block of the message
- block_ready  input  1  permutation core consumes block

Behaviour:
- Reset (rst=0, async): state=FILL, word count cnt=0, dom_pending=0. in_ready=0 during reset, then 1. block_valid=0, block_last=0. Buffer contents are don't-care; sipo_buffer has no reset.
- States: FILL, PAD, FLUSH.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: shift one word in (buf_en=1); cnt++.
  - If in_last: bytes at index >= in_bytes are zeroed.
  - If in_bytes<WIDTH/8: byte[in_bytes]=DOMAIN. Otherwise set dom_pending=1.
  - If the word lands at cnt==RATE_WORDS-1 and padding is complete for this block (not dom_pending): byte[WIDTH/8-1] |= 8'h80.
- Transitions out of FILL:
  - After the RATE_WORDS-th shift -> FLUSH.
  - After a last word that leaves cnt<RATE_WORDS -> PAD.
- PAD:
  - in_ready=0. Each cycle shift one generated word.
  - Generated word value: DOMAIN in byte 0 if dom_pending (then clear dom_pending), else 0.
  - The word shifted at cnt==RATE_WORDS-1 gets byte[WIDTH/8-1] |= 8'h80. If DOMAIN and 0x80 coincide in that byte, they are OR'd.
  - After the RATE_WORDS-th shift -> FLUSH.
- FLUSH:
  - block_valid=1, in_ready=0, buf_en=0.
  - block_last=1 iff message ended and no dom_pending.
  - block_o stable while block_valid=1 and block_ready=0.
  - On block_valid&block_ready: cnt=0, block_valid drops next cycle.
  - Next state: PAD if dom_pending, else FILL.
- Full-width last word landing in the final block slot:
  - The block is emitted with block_last=0 and no 0x80.
  - The following block is all-pad: word0=DOMAIN, top byte of last word=0x80, block_last=1.
- Empty message (in_last, in_bytes=0): word0 byte0=DOMAIN, then PAD.
- Latency: block_valid asserts the cycle after the RATE_WORDS-th shift.
- Throughput: 1 word/cycle in FILL. No input is accepted in the FLUSH cycle(s).
- in_valid with in_last while in PAD/FLUSH is not consumed (in_ready=0); data must be held by the source.
- Reset mid-block discards the partial block.

Optional Feature:
- SIPO_ABSORB_CTRL_PERF_EN.
- Defined:
  - Adds output perf_blocks[31:0], counting block_valid&block_ready handshakes.
  - Adds output perf_stall[31:0], counting cycles with in_valid=1 and in_ready=0.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and counters absent. Functional behaviour is identical.

Decomposition:
- Package shake_pkg holds:
  - State enum absorb_state_t {FILL, PAD, FLUSH}.
  - Constants SHAKE128_RATE_WORDS=21, SHAKE256_RATE_WORDS=17, SHAKE_DOMAIN=8'h1F, PAD_END=8'h80.
- One sub-module: sipo_buffer (WIDTH, DEPTH=RATE_WORDS), fed by the controller's buf_en and padded word. Its output is block_o.

Test Plan:
- Reset with in_valid=1: rst=0 then release -> block_valid=0, in_ready=1 the cycle after release, no shift during reset.
- 21 full words 0..20, last on word 20 with in_bytes=8, block_ready=1:
  - Block 1 is words 0..20 with no 0x80 and block_last=0.
  - Block 2 is word0=64'h1F, word20=64'h8000_0000_0000_0000, others 0, block_last=1.
- Empty message (in_last, in_bytes=0, RATE_WORDS=17):
  - word0=64'h1F, word16=64'h80<<56, block_last=1.
  - block_valid asserts exactly 17 cycles after acceptance.
- Last word at slot 20 with in_bytes=3, data 64'hAABBCC -> word20=64'h8000_0000_1FAA_BBCC, single block, block_last=1.
- Back-pressure: hold block_ready=0 for 10 cycles in FLUSH -> block_o stable, in_ready=0, block_valid held. With PERF_EN, perf_stall=10 when in_valid=1.
- Reset mid-fill after 5 words, then a 1-word message with in_bytes=8 -> output block has no residue from the 5 words: word0=data, word1=64'h1F.
